// File: rtl/mips_regfile_pkg.sv
// Shared types for the MIPS register file and its pending-write scoreboard.
package mips_regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;

  // Destination tag: used both for decode-time issue and write-back completion.
  typedef struct packed {
    logic      en;
    reg_addr_t addr;
  } dst_req_t;

  function automatic logic dst_live(input dst_req_t req);
    return req.en && (req.addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy bits: set on issue, cleared on write-back, set wins on collision.
module regfile_busy_tracker
  import mips_regfile_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  dst_req_t  issue,
  input  dst_req_t  wb,
  input  reg_addr_t rs_addr,
  input  reg_addr_t rt_addr,
  output logic      rs_busy,
  output logic      rt_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  // Clear first, then set, so a new producer supersedes the completing one.
  always_comb begin
    busy_nxt = busy;
    if (dst_live(wb))    busy_nxt[wb.addr]    = 1'b0;
    if (dst_live(issue)) busy_nxt[issue.addr] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // A completing write this cycle is bypassed, so its consumer need not stall.
  assign rs_busy = busy[rs_addr] && !(wb.en && wb.addr == rs_addr);
  assign rt_busy = busy[rt_addr] && !(wb.en && wb.addr == rt_addr);

endmodule

// File: rtl/regfile_scoreboard.sv
// MIPS register file with write-through bypass on both read ports and a busy scoreboard.
module regfile_scoreboard
  import mips_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output logic                  stall
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  dst_req_t wb_req, issue_req;
  logic     wr_live;

  assign wb_req    = '{en: wr_en,    addr: wr_addr};
  assign issue_req = '{en: issue_en, addr: issue_addr};
  assign wr_live   = dst_live(wb_req);

  // $0 is never written, so its entry stays at the reset value of zero.
  always_ff @(posedge clk) begin
    if (!rst_n)       regs <= '0;
    else if (wr_live) regs[wr_addr] <= wr_data;
  end

  assign rs_data = (wr_live && wr_addr == rs_addr) ? wr_data : regs[rs_addr];
  assign rt_data = (wr_live && wr_addr == rt_addr) ? wr_data : regs[rt_addr];

  regfile_busy_tracker #(.NUM_REGS(NUM_REGS)) u_busy (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (issue_req),
    .wb      (wb_req),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_busy (rs_busy),
    .rt_busy (rt_busy)
  );

  assign stall = rs_busy || rt_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, $0, bypass, scoreboard set/clear.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, wr_addr, issue_addr;
  logic [31:0] rs_data, rt_data, wr_data;
  logic        wr_en, issue_en;
  logic        rs_busy, rt_busy, stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rs_busy    (rs_busy),
    .rt_busy    (rt_busy),
    .stall      (stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; issue_en = 1'b0;
    wr_addr = 5'd0; issue_addr = 5'd0; wr_data = 32'h0;
  endtask

  task automatic test_reset();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    issue_en = 1'b1; issue_addr = 5'd5;
    tick();
    idle(); rs_addr = 5'd5; rt_addr = 5'd5; #1;
    checks++; if (rs_data !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_data got %h want %h", rs_data, 32'hDEADBEEF); end
    checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b want 1", rs_busy); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL reset_rs_data got %h want 0", rs_data); end
    checks++; if (rt_data !== 32'h0) begin errors++; $display("FAIL reset_rt_data got %h want 0", rt_data); end
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL reset_rs_busy got %b want 0", rs_busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
  endtask

  task automatic test_zero();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    issue_en = 1'b1; issue_addr = 5'd0;
    rs_addr = 5'd0; rt_addr = 5'd0; #1;
    checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL zero_bypass got %h want 0", rs_data); end
    tick(); idle(); #1;
    checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL zero_write got %h want 0", rs_data); end
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", rs_busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got %b want 0", stall); end
  endtask

  task automatic test_write_bypass();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h12345678;
    rt_addr = 5'd31; rs_addr = 5'd7; #1;
    checks++; if (rt_data !== 32'h12345678) begin errors++; $display("FAIL bypass_rt got %h want %h", rt_data, 32'h12345678); end
    checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL bypass_other_port got %h want 0", rs_data); end
    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFEF00D; #1;
    checks++; if (rt_data !== 32'h12345678) begin errors++; $display("FAIL readback_31 got %h want %h", rt_data, 32'h12345678); end
    checks++; if (rs_data !== 32'hCAFEF00D) begin errors++; $display("FAIL bypass_rs got %h want %h", rs_data, 32'hCAFEF00D); end
    tick(); idle(); #1;
    checks++; if (rs_data !== 32'hCAFEF00D) begin errors++; $display("FAIL readback_7 got %h want %h", rs_data, 32'hCAFEF00D); end
  endtask

  task automatic test_scoreboard();
    issue_en = 1'b1; issue_addr = 5'd8;
    tick(); idle(); rs_addr = 5'd8; rt_addr = 5'd0; #1;
    checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL sb_busy8 got %b want 1", rs_busy); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall got %b want 1", stall); end
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h0000A5A5; #1;
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL sb_wb_mask got %b want 0", rs_busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_wb_stall got %b want 0", stall); end
    checks++; if (rs_data !== 32'h0000A5A5) begin errors++; $display("FAIL sb_wb_data got %h want %h", rs_data, 32'h0000A5A5); end
    tick(); idle(); #1;
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL sb_cleared8 got %b want 0", rs_busy); end
    issue_en = 1'b1; issue_addr = 5'd12;
    tick(); idle(); rt_addr = 5'd12; #1;
    checks++; if (rt_busy !== 1'b1) begin errors++; $display("FAIL sb_rt_busy got %b want 1", rt_busy); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_rt_stall got %b want 1", stall); end
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL sb_rs_idle got %b want 0", rs_busy); end
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h1;
    tick(); idle(); #1;
    checks++; if (rt_busy !== 1'b0) begin errors++; $display("FAIL sb_cleared12 got %b want 0", rt_busy); end
  endtask

  task automatic test_set_clear();
    issue_en = 1'b1; issue_addr = 5'd9;
    tick();
    issue_en = 1'b1; issue_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    tick(); idle(); rs_addr = 5'd9; rt_addr = 5'd10; #1;
    checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL same_addr_set_wins got %b want 1", rs_busy); end
    issue_en = 1'b1; issue_addr = 5'd10; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9A;
    tick(); idle(); #1;
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL diff_addr_clear9 got %b want 0", rs_busy); end
    checks++; if (rt_busy !== 1'b1) begin errors++; $display("FAIL diff_addr_set10 got %b want 1", rt_busy); end
    checks++; if (rs_data !== 32'h9A) begin errors++; $display("FAIL diff_addr_data9 got %h want %h", rs_data, 32'h9A); end
  endtask

  task automatic test_reset_mid();
    issue_en = 1'b1; issue_addr = 5'd3;
    tick();
    issue_en = 1'b1; issue_addr = 5'd4;
    tick(); idle(); rs_addr = 5'd3; rt_addr = 5'd4; #1;
    checks++; if (rs_busy !== 1'b1 || rt_busy !== 1'b1) begin errors++; $display("FAIL mid_preset got %b%b want 11", rs_busy, rt_busy); end
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
    issue_en = 1'b1; issue_addr = 5'd6;
    tick(); rst_n = 1'b1; idle(); #1;
    checks++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b%b want 00", rs_busy, rt_busy); end
    checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL mid_reg3 got %h want 0", rs_data); end
    rs_addr = 5'd6; rt_addr = 5'd10; #1;
    checks++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin errors++; $display("FAIL mid_busy6_10 got %b%b want 00", rs_busy, rt_busy); end
    rs_addr = 5'd31; rt_addr = 5'd7; #1;
    checks++; if (rs_data !== 32'h0 || rt_data !== 32'h0) begin errors++; $display("FAIL mid_regs_cleared got %h %h want 0 0", rs_data, rt_data); end
  endtask

  initial begin
    rst_n = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0;
    idle();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_zero();
    test_write_bypass();
    test_scoreboard();
    test_set_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
